// File: rtl/ttd_pkg.sv
// Shared types and default parameters for the time-to-digital conversion sequencer.
package ttd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISCH = 3'd1,
    RAMP  = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DEF_CNT_W       = 11;
  localparam int DEF_OUT_W       = 9;
  localparam int DEF_OFFSET      = 509;
  localparam int DEF_RST_CYCLES  = 16;
  localparam int DEF_AVG_LOG2    = 2;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ttd_sync_edge.sv
// Multi-flop synchroniser for the asynchronous comparator output with a rising-edge pulse.
module ttd_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/ttd_conv_sequencer.sv
// Sequences capacitor discharge, ramp timing, offset/saturation, averaging and
// valid/ready hand-off for the comparator/capacitor time-to-digital front end.
module ttd_conv_sequencer
  import ttd_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int OFFSET      = DEF_OFFSET,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             cmp_in,
  output logic             rst_cap,
  output logic             busy,
  output logic [OUT_W-1:0] data_out,
  output logic             ovf,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam int ACC_W    = OUT_W + AVG_LOG2;
  localparam int IDX_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int IDX_LAST = (1 << AVG_LOG2) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0] SAT     = '1;

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [ACC_W-1:0]   acc_r;
  logic               tmo_r;
  logic               ovf_flag_r;
  logic               rst_cap_r;
  logic               busy_r;
  logic               data_valid_r;
  logic [OUT_W-1:0]   data_out_r;
  logic               ovf_r;
  logic               rise_s;
  logic [OUT_W-1:0]   sample_s;
  logic [ACC_W-1:0]   acc_next_s;

  // Offset removal with floor at zero and ceiling at full scale; a timeout reads as full scale.
  function automatic logic [OUT_W-1:0] calc_sample(input logic [CNT_W-1:0] cnt,
                                                   input logic             tmo);
    logic [CNT_W:0] diff;
    diff = {1'b0, cnt} - (CNT_W+1)'(OFFSET);
    if (tmo) begin
      calc_sample = SAT;
    end else if (diff[CNT_W]) begin
      calc_sample = '0;
    end else if (diff[CNT_W-1:0] > CNT_W'(SAT)) begin
      calc_sample = SAT;
    end else begin
      calc_sample = diff[OUT_W-1:0];
    end
  endfunction

  ttd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cmp_in),
    .rise     (rise_s)
  );

  assign sample_s   = calc_sample(cnt_r, tmo_r);
  assign acc_next_s = acc_r + ACC_W'(sample_s);

  // conversion FSM; the shared counter times both discharge and ramp, and holds the capture in CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      idx_r        <= '0;
      acc_r        <= '0;
      tmo_r        <= 1'b0;
      ovf_flag_r   <= 1'b0;
      rst_cap_r    <= 1'b1;
      busy_r       <= 1'b0;
      data_valid_r <= 1'b0;
      data_out_r   <= '0;
      ovf_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start || cont) begin
            state_r    <= DISCH;
            busy_r     <= 1'b1;
            cnt_r      <= '0;
            idx_r      <= '0;
            acc_r      <= '0;
            ovf_flag_r <= 1'b0;
          end
        end
        DISCH: begin
          if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
            state_r   <= RAMP;
            cnt_r     <= '0;
            tmo_r     <= 1'b0;
            rst_cap_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RAMP: begin
          // at count 0 the previous sync sample still belongs to DISCH, so no edge is accepted
          if (rise_s && (cnt_r != '0)) begin
            state_r   <= CALC;
            rst_cap_r <= 1'b1;
          end else if (cnt_r == CNT_MAX) begin
            state_r   <= CALC;
            tmo_r     <= 1'b1;
            rst_cap_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        CALC: begin
          acc_r      <= acc_next_s;
          ovf_flag_r <= ovf_flag_r | tmo_r;
          if (idx_r == IDX_W'(IDX_LAST)) begin
            state_r      <= DONE;
            data_valid_r <= 1'b1;
            data_out_r   <= acc_next_s[ACC_W-1:AVG_LOG2];
            ovf_r        <= ovf_flag_r | tmo_r;
          end else begin
            state_r <= DISCH;
            idx_r   <= idx_r + IDX_W'(1);
            cnt_r   <= '0;
          end
        end
        DONE: begin
          if (data_ready) begin
            data_valid_r <= 1'b0;
            if (cont) begin
              state_r    <= DISCH;
              cnt_r      <= '0;
              idx_r      <= '0;
              acc_r      <= '0;
              ovf_flag_r <= 1'b0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          rst_cap_r    <= 1'b1;
          busy_r       <= 1'b0;
          data_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rst_cap    = rst_cap_r;
  assign busy       = busy_r;
  assign data_out   = data_out_r;
  assign ovf        = ovf_r;
  assign data_valid = data_valid_r;

endmodule
